// File: rtl/m_mem_access_ctrl_pkg.sv
// rtl/m_mem_access_ctrl_pkg.sv - shared encodings and helpers for the memory access unit
//
// Purpose : size encodings, exception codes, FSM state encoding and the
//           combinational helpers used to build a bus request from an M-stage
//           access (alignment test, byte enables, store lane replication).
// Ports   : none (package).
package m_mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Reserved size is treated as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byteen_of(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data into every lane lets the bridge pick any lane
    // purely from the byte enables, with no shifter on the bus side.
    function automatic logic [31:0] lanes_of(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/m_mem_access_ctrl_if.sv
// rtl/m_mem_access_ctrl_if.sv - request/acknowledge bus between access unit and system bridge
//
// Purpose : groups the bridge-side handshake signals.
// Signals : bus_req    request, held until bus_ack
//           bus_we     1=write
//           bus_addr   word-aligned byte address
//           bus_byteen byte lane enables
//           bus_wdata  lane-replicated store data
//           bus_ack    one-cycle completion from the bridge
//           bus_rdata  read word, valid with bus_ack
// Modports: master = access unit, slave = bridge.
interface m_mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_byteen;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/m_load_ext.sv
// rtl/m_load_ext.sv - load lane select with zero/sign extension
//
// Purpose : picks the addressed byte/half out of a returned word and extends
//           it to 32 bits; word loads pass through and ignore sign_i.
// Ports   : off_i  [1:0]  low address bits of the access
//           size_i [1:0]  access size encoding
//           sign_i        1=sign extend, 0=zero extend
//           word_i [31:0] word returned by the bridge
//           data_o [31:0] extended load result
module m_load_ext
    import m_mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        case (size_i)
            SZ_B:    data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/m_mem_access_ctrl.sv
// rtl/m_mem_access_ctrl.sv - M-stage load/store access unit with bridge handshake
//
// Purpose : turns an M-stage memory instruction into one bridge transaction,
//           stalls the pipeline until it completes and returns the extended
//           load result or an alignment/bus exception.
// Macro   : MEM_ACCESS_TIMEOUT_EN - when defined, a WAIT that sees no ack for
//           TIMEOUT_CYCLES cycles ends with a bus error (code 7).
// Ports   : clk, reset      clock, synchronous active-high reset
//           m_req/m_we/m_size/m_sign/m_addr/m_wdata  access from M stage
//           m_stall         freeze F/D/E/M
//           m_done          one-cycle completion pulse
//           m_rdata         extended load result, valid with m_done
//           m_exc/m_exc_code  fault flag and code, valid with m_done
//           bus             bridge interface (master side)
module m_mem_access_ctrl
    import m_mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [1:0]        m_size,
    input  logic              m_sign,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              m_stall,
    output logic              m_done,
    output logic [31:0]       m_rdata,
    output logic              m_exc,
    output logic [4:0]        m_exc_code,
    m_mem_access_ctrl_if.master bus
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_e            state_q;
    logic              bus_req_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        byteen_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              exc_q;
    logic [4:0]        code_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              misaligned_d;
    logic [3:0]        byteen_d;
    logic [31:0]       lanes_d;
    logic              timeout_d;
    logic [31:0]       ext_data;

    assign misaligned_d = is_misaligned(m_size, m_addr[1:0]);
    assign byteen_d     = byteen_of(m_size, m_addr[1:0]);
    assign lanes_d      = lanes_of(m_size, m_wdata);

    // Compared against TIMEOUT_CYCLES-1 because the cycle that matches is
    // itself the last ack-less WAIT cycle. Without the macro this is constant
    // zero and the counter is dead logic.
    assign timeout_d = TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            off_q      <= 2'b00;
            bus_addr_q <= '0;
            byteen_q   <= 4'b0000;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            code_q     <= EXC_NONE;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_req) begin
                        if (misaligned_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                            code_q  <= m_we ? EXC_ADES : EXC_ADEL;
                        end else begin
                            state_q    <= ST_WAIT;
                            bus_req_q  <= 1'b1;
                            we_q       <= m_we;
                            size_q     <= m_size;
                            sign_q     <= m_sign;
                            off_q      <= m_addr[1:0];
                            bus_addr_q <= {m_addr[ADDR_W-1:2], 2'b00};
                            byteen_q   <= byteen_d;
                            wdata_q    <= lanes_d;
                            cnt_q      <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        rdata_q   <= bus.bus_rdata;
                    end else if (timeout_d) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        exc_q     <= 1'b1;
                        code_q    <= EXC_BUS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    exc_q   <= 1'b0;
                    code_q  <= EXC_NONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    m_load_ext u_load_ext (
        .off_i  (off_q),
        .size_i (size_q),
        .sign_i (sign_q),
        .word_i (rdata_q),
        .data_o (ext_data)
    );

    // The DONE cycle is the one where the pipeline is allowed to advance.
    assign m_stall    = m_req && (state_q != ST_DONE);
    assign m_done     = done_q;
    assign m_exc      = exc_q;
    assign m_exc_code = code_q;
    // Faults and stores return zero; a load result is only presented with m_done.
    assign m_rdata    = (done_q && !exc_q && !we_q) ? ext_data : 32'd0;

    assign bus.bus_req    = bus_req_q;
    assign bus.bus_we     = we_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_byteen = byteen_q;
    assign bus.bus_wdata  = wdata_q;

endmodule

// File: tb/tb_m_mem_access_ctrl.sv
// tb/tb_m_mem_access_ctrl.sv - scoreboard bench for m_mem_access_ctrl
module tb_m_mem_access_ctrl;

    localparam int T = 4;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_sign;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_stall;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        m_exc;
    logic [4:0]  m_exc_code;

    m_mem_access_ctrl_if #(.ADDR_W(32)) bus_if ();

    m_mem_access_ctrl #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_size     (m_size),
        .m_sign     (m_sign),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_stall    (m_stall),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .m_exc      (m_exc),
        .m_exc_code (m_exc_code),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          delay;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stray_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int n;
        if (size == 2'd3) return 1'b1;
        n = 1 << size;
        return (int'(addr % 4) % n) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int n;
        int off;
        n   = 1 << size;
        off = int'(addr % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        int n;
        n = 1 << size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] word);
        longint v;
        longint span;
        int n;
        n    = 1 << size;
        span = longint'(1) << (8 * n);
        v    = (longint'(word) >> (8 * int'(addr % 4))) % span;
        if (sign && n < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- result monitor ----------------
    resp_t mon_e;
    always @(negedge clk) begin
        if (m_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (rdata=0x%08h code=%0d)", m_rdata, m_exc_code);
            end else begin
                mon_e = exp_q.pop_front();
                check("m_rdata", m_rdata, mon_e.rdata);
                check("m_exc", 32'(m_exc), 32'(mon_e.exc));
                check("m_exc_code", 32'(m_exc_code), 32'(mon_e.code));
            end
        end
    end

    // ---------------- bridge model ----------------
    bus_t cur;
    bit   active = 1'b0;
    int   wcnt   = 0;
    always @(negedge clk) begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        if (reset === 1'b1) begin
            active = 1'b0;
        end else if (bus_if.bus_req === 1'b1) begin
            if (!active) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bus_req actual=1 expected=0 addr=0x%08h", bus_if.bus_addr);
                end else begin
                    cur    = bus_q.pop_front();
                    active = 1'b1;
                    wcnt   = 0;
                    check("bus_addr", bus_if.bus_addr, cur.addr);
                    check("bus_byteen", 32'(bus_if.bus_byteen), 32'(cur.be));
                    check("bus_we", 32'(bus_if.bus_we), 32'(cur.we));
                    if (cur.we) check("bus_wdata", bus_if.bus_wdata, cur.wdata);
                end
            end else begin
                wcnt++;
                check("hold_addr", bus_if.bus_addr, cur.addr);
                check("hold_byteen", 32'(bus_if.bus_byteen), 32'(cur.be));
                if (cur.we) check("hold_wdata", bus_if.bus_wdata, cur.wdata);
            end
            if (active && cur.delay >= 0 && wcnt == cur.delay) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = cur.rword;
            end
        end else begin
            active = 1'b0;
            if (stray_ack) bus_if.bus_ack = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle, with m_req low.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rword, input int delay);
        resp_t e;
        bus_t  b;
        int    exp_lat;
        int    n;
        int    stalls;
        bit    seen;
        if (ref_misaligned(size, addr)) begin
            e.exc = 1'b1; e.code = we ? 5'd5 : 5'd4; e.rdata = 32'd0;
            exp_lat = 1;
        end else begin
            b.we = we; b.addr = addr & 32'hFFFF_FFFC; b.be = ref_be(size, addr);
            b.wdata = ref_lanes(size, wdata); b.rword = rword; b.delay = delay;
            bus_q.push_back(b);
            if (TO_EN && (delay < 0 || delay >= T)) begin
                e.exc = 1'b1; e.code = 5'd7; e.rdata = 32'd0;
                exp_lat = 1 + T;
            end else begin
                e.exc = 1'b0; e.code = 5'd0;
                e.rdata = we ? 32'd0 : ref_load(size, sign, addr, rword);
                exp_lat = 2 + delay;
            end
        end
        exp_q.push_back(e);
        m_req = 1'b1; m_we = we; m_size = size; m_sign = sign; m_addr = addr; m_wdata = wdata;
        n = 0; stalls = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (m_stall) stalls++;
            if (m_done) seen = 1'b1;
            else n++;
        end
        check("done_latency", 32'(n), 32'(exp_lat));
        check("stall_cycles", 32'(stalls), 32'(exp_lat));
        @(posedge clk);
        #1;
        m_req = 1'b0;
        if (!seen) begin
            exp_q.delete();
            bus_q.delete();
            apply_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int          stalls;
    int          dones;
    bus_t        hb;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] msk;

    initial begin
        reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_size = 2'd0; m_sign = 1'b0;
        m_addr = 32'd0; m_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_stall", 32'(m_stall), 0);
        check("rst_m_done", 32'(m_done), 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_m_exc", 32'(m_exc), 0);
        check("rst_m_exc_code", 32'(m_exc_code), 0);
        check("rst_bus_req", 32'(bus_if.bus_req), 0);
        check("rst_bus_we", 32'(bus_if.bus_we), 0);
        check("rst_bus_addr", bus_if.bus_addr, 0);
        check("rst_bus_byteen", 32'(bus_if.bus_byteen), 0);
        check("rst_bus_wdata", bus_if.bus_wdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases
        do_access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0);
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 32'h0, 0);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h1234, 32'h0, 0);
        do_access(1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h1234, 32'h0, 0);
        do_access(1'b0, 2'd2, 1'b1, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3);
        do_access(1'b1, 2'd2, 1'b0, 32'h0000_2004, 32'h1357_9BDF, 32'h0, 5);
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_8000, 0);

        // Ack while idle must be ignored
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stray_ack = 1'b0;

        // Reset two cycles into WAIT abandons the access
        hb.we = 1'b0; hb.addr = 32'h0000_5004; hb.be = 4'hF; hb.wdata = 32'd0; hb.rword = 32'd0; hb.delay = -1;
        bus_q.push_back(hb);
        m_req = 1'b1; m_we = 1'b0; m_size = 2'd2; m_sign = 1'b0; m_addr = 32'h0000_5004;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_req = 1'b0;
        @(negedge clk);
        check("pre_reset_bus_req", 32'(bus_if.bus_req), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_bus_req", 32'(bus_if.bus_req), 0);
        check("post_reset_m_done", 32'(m_done), 0);
        @(posedge clk);
        #1;
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_5007, 32'h0, 32'hF0AB_CDEF, 0);

        // No ack at all: bus error with the timeout, indefinite stall without it
        if (TO_EN) begin
            do_access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, -1);
        end else begin
            hb.we = 1'b0; hb.addr = 32'h0000_4000; hb.be = 4'hF; hb.wdata = 32'd0; hb.rword = 32'd0; hb.delay = -1;
            bus_q.push_back(hb);
            m_req = 1'b1; m_we = 1'b0; m_size = 2'd2; m_addr = 32'h0000_4000;
            stalls = 0;
            dones  = 0;
            repeat (100) begin
                @(negedge clk);
                if (m_stall) stalls++;
                if (m_done) dones++;
            end
            check("hang_stall_cycles", 32'(stalls), 100);
            check("hang_done_count", 32'(dones), 0);
            apply_reset();
        end

        // Randomized accesses, back to back
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) begin
                msk = (32'd1 << sz) - 32'd1;
                a   = a & ~msk;
            end
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                      $urandom, $urandom, $urandom_range(0, 6));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("leftover_resp", 32'(exp_q.size()), 0);
        check("leftover_bus", 32'(bus_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
